// File: rtl/e203_exu_csr_port_arb.sv
// CSR port arbiter/sequencer: core vs debug, grant -> access -> respond.
// Define E203_CSR_ARB_RR_EN for round-robin arbitration; otherwise core has fixed priority.
module e203_exu_csr_port_arb #(
    parameter int XLEN = 32,
    parameter int IDXW = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            c_req_valid,
    output logic            c_req_ready,
    input  logic [IDXW-1:0] c_req_idx,
    input  logic [XLEN-1:0] c_req_wdat,
    input  logic            c_req_wr,
    input  logic            c_req_rd,
    output logic            c_rsp_valid,
    input  logic            c_rsp_ready,
    output logic [XLEN-1:0] c_rsp_rdat,
    output logic            c_rsp_err,
    input  logic            d_req_valid,
    output logic            d_req_ready,
    input  logic [IDXW-1:0] d_req_idx,
    input  logic [XLEN-1:0] d_req_wdat,
    input  logic            d_req_wr,
    input  logic            d_req_rd,
    output logic            d_rsp_valid,
    input  logic            d_rsp_ready,
    output logic [XLEN-1:0] d_rsp_rdat,
    output logic            d_rsp_err,
    output logic            csr_ena,
    output logic            csr_wr_en,
    output logic            csr_rd_en,
    output logic [IDXW-1:0] csr_idx,
    output logic [XLEN-1:0] wbck_csr_dat,
    input  logic [XLEN-1:0] read_csr_dat,
    input  logic            csr_access_ilgl,
    output logic            arb_owner
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      state;
    logic            owner;
    logic [IDXW-1:0] idx_q;
    logic [XLEN-1:0] wdat_q;
    logic [XLEN-1:0] rdat_q;
    logic            wr_q;
    logic            rd_q;
    logic            err_q;

    logic            is_idle;
    logic            is_acc;
    logic            is_resp;
    logic            win;
    logic            hs;
    logic            rsp_ack;

    assign is_idle = (state == S_IDLE);
    assign is_acc  = (state == S_ACC);
    assign is_resp = (state == S_RESP);

`ifdef E203_CSR_ARB_RR_EN
    // last_gnt: 1 = debug was granted most recently
    logic last_gnt;

    always_comb begin
        win = ~c_req_valid;
        if (c_req_valid && d_req_valid) begin
            win = ~last_gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (hs) begin
            last_gnt <= win;
        end
    end
`else
    assign win = ~c_req_valid;
`endif

    assign c_req_ready = is_idle & c_req_valid & ~win;
    assign d_req_ready = is_idle & d_req_valid & win;
    assign hs          = c_req_ready | d_req_ready;
    assign rsp_ack     = owner ? d_rsp_ready : c_rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            owner  <= 1'b0;
            idx_q  <= '0;
            wdat_q <= '0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            rdat_q <= '0;
            err_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (hs) begin
                        state  <= S_ACC;
                        owner  <= win;
                        idx_q  <= win ? d_req_idx  : c_req_idx;
                        wdat_q <= win ? d_req_wdat : c_req_wdat;
                        wr_q   <= win ? d_req_wr   : c_req_wr;
                        rd_q   <= win ? d_req_rd   : c_req_rd;
                    end
                end
                S_ACC: begin
                    rdat_q <= (rd_q && !csr_access_ilgl) ? read_csr_dat : '0;
                    err_q  <= csr_access_ilgl;
                    state  <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ack) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Illegal writes are squashed before they reach the register file
    assign csr_ena      = is_acc;
    assign csr_wr_en    = is_acc & wr_q & ~csr_access_ilgl;
    assign csr_rd_en    = is_acc & rd_q;
    assign csr_idx      = is_acc ? idx_q  : '0;
    assign wbck_csr_dat = is_acc ? wdat_q : '0;

    assign c_rsp_valid  = is_resp & ~owner;
    assign d_rsp_valid  = is_resp & owner;
    assign c_rsp_rdat   = c_rsp_valid ? rdat_q : '0;
    assign d_rsp_rdat   = d_rsp_valid ? rdat_q : '0;
    assign c_rsp_err    = c_rsp_valid & err_q;
    assign d_rsp_err    = d_rsp_valid & err_q;
    assign arb_owner    = owner;

endmodule

// File: tb/tb_e203_exu_csr_port_arb.sv
// Bench for e203_exu_csr_port_arb: per-cycle transaction model plus directed checks.
`timescale 1ns/1ps
module tb_e203_exu_csr_port_arb;

    logic        clk = 0;
    logic        rst = 1;
    logic        c_req_valid = 0, c_req_wr = 0, c_req_rd = 0;
    logic [11:0] c_req_idx = 0;
    logic [31:0] c_req_wdat = 0;
    logic        c_rsp_ready = 1;
    logic        d_req_valid = 0, d_req_wr = 0, d_req_rd = 0;
    logic [11:0] d_req_idx = 0;
    logic [31:0] d_req_wdat = 0;
    logic        d_rsp_ready = 1;
    logic [31:0] read_csr_dat = 0;
    logic        csr_access_ilgl = 0;

    logic        c_req_ready, c_rsp_valid, c_rsp_err;
    logic        d_req_ready, d_rsp_valid, d_rsp_err;
    logic [31:0] c_rsp_rdat, d_rsp_rdat, wbck_csr_dat;
    logic        csr_ena, csr_wr_en, csr_rd_en, arb_owner;
    logic [11:0] csr_idx;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef E203_CSR_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    e203_exu_csr_port_arb #(.XLEN(32), .IDXW(12)) dut (
        .clk(clk), .rst(rst),
        .c_req_valid(c_req_valid), .c_req_ready(c_req_ready),
        .c_req_idx(c_req_idx), .c_req_wdat(c_req_wdat),
        .c_req_wr(c_req_wr), .c_req_rd(c_req_rd),
        .c_rsp_valid(c_rsp_valid), .c_rsp_ready(c_rsp_ready),
        .c_rsp_rdat(c_rsp_rdat), .c_rsp_err(c_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
        .d_req_idx(d_req_idx), .d_req_wdat(d_req_wdat),
        .d_req_wr(d_req_wr), .d_req_rd(d_req_rd),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
        .d_rsp_rdat(d_rsp_rdat), .d_rsp_err(d_rsp_err),
        .csr_ena(csr_ena), .csr_wr_en(csr_wr_en), .csr_rd_en(csr_rd_en),
        .csr_idx(csr_idx), .wbck_csr_dat(wbck_csr_dat),
        .read_csr_dat(read_csr_dat), .csr_access_ilgl(csr_access_ilgl),
        .arb_owner(arb_owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: one in-flight access, described by its age since grant.
    // age < 0: no transaction; age 0: access cycle; age >= 1: awaiting owner's ack.
    bit          live = 0;
    int          age = -1;
    bit          t_own, t_wr, t_rd, t_err, last_dbg = 1;
    logic [11:0] t_idx;
    logic [31:0] t_wdat, t_rdat;

    always @(negedge clk) begin
        int  w;
        bit  acc, resp;
        if (live) begin
            w = -1;
            if (age < 0) begin
                if (c_req_valid && d_req_valid) w = (RR && !last_dbg) ? 1 : 0;
                else if (c_req_valid) w = 0;
                else if (d_req_valid) w = 1;
            end
            acc  = (age == 0);
            resp = (age >= 1);
            chk("c_req_ready", {31'd0, c_req_ready}, {31'd0, w == 0});
            chk("d_req_ready", {31'd0, d_req_ready}, {31'd0, w == 1});
            chk("csr_ena", {31'd0, csr_ena}, {31'd0, acc});
            chk("csr_rd_en", {31'd0, csr_rd_en}, {31'd0, acc && t_rd});
            chk("csr_wr_en", {31'd0, csr_wr_en}, {31'd0, acc && t_wr && !csr_access_ilgl});
            chk("csr_idx", {20'd0, csr_idx}, acc ? {20'd0, t_idx} : 32'd0);
            chk("wbck_csr_dat", wbck_csr_dat, acc ? t_wdat : 32'd0);
            chk("c_rsp_valid", {31'd0, c_rsp_valid}, {31'd0, resp && !t_own});
            chk("d_rsp_valid", {31'd0, d_rsp_valid}, {31'd0, resp && t_own});
            chk("arb_owner", {31'd0, arb_owner}, {31'd0, t_own});
            if (resp) begin
                chk("rsp_rdat", t_own ? d_rsp_rdat : c_rsp_rdat, t_rdat);
                chk("rsp_err", {31'd0, t_own ? d_rsp_err : c_rsp_err}, {31'd0, t_err});
            end
        end
        if (rst) begin
            live = 1; age = -1; t_own = 0; last_dbg = 1;
        end else if (live) begin
            if (age < 0) begin
                if (w >= 0) begin
                    age = 0; t_own = (w == 1); last_dbg = t_own;
                    t_idx  = t_own ? d_req_idx  : c_req_idx;
                    t_wdat = t_own ? d_req_wdat : c_req_wdat;
                    t_wr   = t_own ? d_req_wr   : c_req_wr;
                    t_rd   = t_own ? d_req_rd   : c_req_rd;
                end
            end else if (age == 0) begin
                t_rdat = (t_rd && !csr_access_ilgl) ? read_csr_dat : 32'd0;
                t_err  = csr_access_ilgl;
                age = 1;
            end else if (t_own ? d_rsp_ready : c_rsp_ready) begin
                age = -1;
            end else begin
                age++;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_rdy(input bit dbg, input string nm);
        bit ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = dbg ? d_req_ready : c_req_ready;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: got timeout want ready", nm);
        end
    endtask

    task automatic c_issue(input logic [11:0] idx, input logic [31:0] wd, input bit wr, input bit rd);
        c_req_idx = idx; c_req_wdat = wd; c_req_wr = wr; c_req_rd = rd; c_req_valid = 1;
    endtask

    bit own_seq [4];

    initial begin
        repeat (3) step();
        rst = 0;
        @(negedge clk);
        chk("rst_owner", {31'd0, arb_owner}, 32'd0);
        chk("rst_ena", {31'd0, csr_ena}, 32'd0);
        chk("rst_rsp", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd0);
        chk("rst_rdat", c_rsp_rdat | d_rsp_rdat, 32'd0);
        chk("rst_idx", {20'd0, csr_idx}, 32'd0);

        // single core read
        step();
        read_csr_dat = 32'h1888;
        c_issue(12'h300, 32'h0, 0, 1);
        wait_rdy(0, "t1_grant");
        step(); c_req_valid = 0;
        @(negedge clk);
        chk("t1_ena", {29'd0, csr_ena, csr_rd_en, csr_wr_en}, 32'h6);
        chk("t1_idx", {20'd0, csr_idx}, 32'h300);
        @(negedge clk);
        chk("t1_valid", {31'd0, c_rsp_valid}, 32'd1);
        chk("t1_rdat", c_rsp_rdat, 32'h1888);
        chk("t1_err", {31'd0, c_rsp_err}, 32'd0);
        @(negedge clk);
        chk("t1_ena_after", {31'd0, csr_ena}, 32'd0);

        // illegal debug write
        step();
        csr_access_ilgl = 1;
        d_req_idx = 12'h7B0; d_req_wdat = 32'hDEADBEEF; d_req_wr = 1; d_req_rd = 0;
        d_req_valid = 1;
        wait_rdy(1, "t2_grant");
        step(); d_req_valid = 0;
        @(negedge clk);
        chk("t2_wr_en", {30'd0, csr_ena, csr_wr_en}, 32'h2);
        chk("t2_wdat", wbck_csr_dat, 32'hDEADBEEF);
        step(); csr_access_ilgl = 0;
        @(negedge clk);
        chk("t2_err", {30'd0, d_rsp_valid, d_rsp_err}, 32'h3);
        chk("t2_rdat", d_rsp_rdat, 32'd0);

        // response backpressure with a debug request pending
        step();
        read_csr_dat = 32'h55AA;
        c_rsp_ready = 0;
        c_issue(12'h301, 32'h0, 0, 1);
        wait_rdy(0, "t3_grant");
        step(); c_req_valid = 0;
        d_req_idx = 12'h7B1; d_req_wr = 0; d_req_rd = 1; d_req_valid = 1;
        @(negedge clk);
        step(); read_csr_dat = 32'h1234;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold", {c_rsp_valid, csr_ena, d_req_ready, c_rsp_rdat[28:0]},
                {3'b100, 29'h55AA});
            step();
        end
        c_rsp_ready = 1;
        @(negedge clk);
        chk("t3_accept", {31'd0, c_rsp_valid}, 32'd1);
        @(negedge clk);
        chk("t3_next_grant", {31'd0, d_req_ready}, 32'd1);
        step(); d_req_valid = 0;
        repeat (3) step();

        // simultaneous requests, four transactions
        c_issue(12'h340, 32'h0, 0, 1);
        d_req_idx = 12'h7B2; d_req_rd = 1; d_req_valid = 1;
        for (int k = 0; k < 4; k++) begin
            bit got = 0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                got = c_req_ready | d_req_ready;
                own_seq[k] = d_req_ready;
            end
            if (!got) begin
                n_cmp++; n_bad++;
                $display("FAIL t4_grant: got timeout want ready");
            end
            step();
        end
        c_req_valid = 0; d_req_valid = 0;
        for (int k = 0; k < 4; k++) begin
            chk("t4_owner", {31'd0, own_seq[k]}, {31'd0, RR && (k % 2 == 1)});
        end
        repeat (4) step();

        // null request
        read_csr_dat = 32'hFFFF;
        c_issue(12'h7C0, 32'h0, 0, 0);
        wait_rdy(0, "t6_grant");
        step(); c_req_valid = 0;
        @(negedge clk);
        chk("t6_strobes", {29'd0, csr_ena, csr_rd_en, csr_wr_en}, 32'h4);
        @(negedge clk);
        chk("t6_rdat", c_rsp_rdat, 32'd0);
        chk("t6_valid", {31'd0, c_rsp_valid}, 32'd1);
        step();

        // reset while core response is held
        c_rsp_ready = 0;
        c_issue(12'h305, 32'h0, 0, 1);
        wait_rdy(0, "t5_grant");
        step(); c_req_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_resp", {31'd0, c_rsp_valid}, 32'd1);
        step(); rst = 1;
        step(); rst = 0;
        c_issue(12'h306, 32'h0, 0, 1);
        d_req_valid = 1;
        @(negedge clk);
        chk("t5_after_rst", {29'd0, c_rsp_valid, csr_ena, c_req_ready}, 32'h1);
        step(); c_req_valid = 0; c_rsp_ready = 1;
        d_req_valid = 0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/e203_exu_csr_port_arb.md
# e203_exu_csr_port_arb

Two-requester arbiter and sequencer for the single CSR register-file access port of the E203 core. It shares the port between the core ALU CSR path and the debug module's abstract-command CSR path. Each access is a fixed three-phase transaction: grant, access, respond. The block sits between those two requesters and the CSR register file. It owns the `csr_ena/csr_wr_en/csr_rd_en/csr_idx/wbck_csr_dat` port and samples `read_csr_dat/csr_access_ilgl`.

## Interface
Parameters:
- XLEN, 32, CSR data width
- IDXW, 12, CSR index width

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- c_req_valid  in  1  core request valid
- c_req_ready  out  1  core request accepted
- c_req_idx  in  IDXW  core CSR index
- c_req_wdat  in  XLEN  core write data
- c_req_wr  in  1  core write intent
- c_req_rd  in  1  core read intent
- c_rsp_valid  out  1  core response valid
- c_rsp_ready  in  1  core response accepted
- c_rsp_rdat  out  XLEN  core read data
- c_rsp_err  out  1  core illegal-access flag
- d_req_valid, d_req_ready, d_req_idx, d_req_wdat, d_req_wr, d_req_rd, d_rsp_valid, d_rsp_ready, d_rsp_rdat, d_rsp_err  same directions and widths as the core set, for the debug requester
- csr_ena  out  1  CSR port enable
- csr_wr_en  out  1  CSR write strobe
- csr_rd_en  out  1  CSR read strobe
- csr_idx  out  IDXW  CSR index
- wbck_csr_dat  out  XLEN  CSR write data
- read_csr_dat  in  XLEN  CSR read data, valid in the cycle csr_ena is high
- csr_access_ilgl  in  1  CSR illegal-access indication, valid with read_csr_dat
- arb_owner  out  1  current or most recent grant (0 = core, 1 = debug)

## Operation
- The FSM has three states: IDLE, ACCESS, RESP. Reset state is IDLE.
- **IDLE**
  - Winner = arbitration result over the valid requests.
  - `*_req_ready` = IDLE & winner (combinational). The loser's ready stays 0.
  - On handshake: latch idx, wdat, wr, rd and owner; go to ACCESS.
- **ACCESS** (exactly one cycle)
  - csr_ena=1, csr_idx=latched idx, wbck_csr_dat=latched wdat, csr_rd_en=rd.
  - csr_wr_en = wr & ~csr_access_ilgl. An illegal write never reaches the CSR file.
  - Capture into response regs: rdat = (rd & ~ilgl) ? read_csr_dat : 0, and err = csr_access_ilgl.
  - Go to RESP.
- **RESP**
  - Owner's `*_rsp_valid`=1 with the registered rdat and err. Non-owner rsp_valid=0.
  - Hold all response outputs stable until the owner's rsp_ready is seen; then go to IDLE.
- A request with wr=0 and rd=0 still completes: csr_ena pulses, response rdat=0, err=csr_access_ilgl.
- Outside ACCESS: csr_ena, csr_wr_en, csr_rd_en = 0; csr_idx and wbck_csr_dat = 0.
- Requesters must hold req fields stable while req_valid is high and ready is low. Fields are don't-care after the handshake.

## Timing
- Reset values:
  - Response and port outputs: all `*_req_ready`, `*_rsp_valid`, `*_rsp_rdat`, `*_rsp_err` = 0; csr_ena, csr_wr_en, csr_rd_en, csr_idx, wbck_csr_dat = 0.
  - Arbitration state: arb_owner=0; last-grant pointer = debug, so core wins first.
- Request handshake in cycle N.
- ACCESS in cycle N+1; csr_ena is high for exactly that cycle.
- rsp_valid first high in cycle N+2.
- If rsp_ready=1 in N+2, the FSM is in IDLE at N+3 and the next handshake can occur at N+3. Peak rate is one access per 3 cycles.
- Both requesters valid in IDLE: exactly one is granted per the arbitration rule. The other waits with ready=0 and keeps its request pending.
- New requests arriving during ACCESS or RESP see ready=0 and are not lost; they are arbitrated at the next IDLE.
- rsp_ready asserted by the non-owner has no effect.
- rst during ACCESS or RESP:
  - Next cycle is IDLE; csr_ena=0 and rsp_valid=0.
  - The in-flight transaction is discarded with no response.
  - A CSR write already strobed in ACCESS is not undone.
  - The pointer resets to core-first.

## Configuration
- **E203_CSR_ARB_RR_EN defined:** round-robin arbitration.
  - On simultaneous requests, the grant goes to the requester not granted most recently.
  - The last-grant pointer updates on every request handshake.
  - Neither side waits more than one transaction while continuously requesting.
- **Undefined:** fixed priority, core always wins.
  - The pointer is not implemented.
  - Debug is granted only when c_req_valid=0 in IDLE, so debug may starve.

## Test plan
- **Single core access:** core read idx=0x300, read_csr_dat=0x1888 → csr_ena/csr_rd_en high only in N+1, csr_wr_en=0; c_rsp_valid at N+2 with rdat=0x1888, err=0.
- **Illegal write:** debug write idx=0x7B0, wdat=0xDEADBEEF, csr_access_ilgl=1 in ACCESS → csr_wr_en=0; d_rsp_err=1, rdat=0.
- **Response backpressure:** c_rsp_ready low for 5 cycles → rsp_valid, rdat and err held stable; no second csr_ena; the next grant comes 1 cycle after acceptance.
- **Simultaneous requests:** both valid for 4 transactions.
  - With E203_CSR_ARB_RR_EN: owners C, D, C, D.
  - Without it: C, C, C, C while core stays valid.
- **Reset in RESP:** rst asserted while c_rsp_valid=1 and c_rsp_ready=0 → next cycle c_rsp_valid=0, IDLE, and core wins the next simultaneous request.
- **Null request:** wr=0, rd=0 → csr_ena pulses 1 cycle, csr_rd_en=csr_wr_en=0, rsp rdat=0.
